// File: rtl/mach_v_mdu_pkg.sv
// Shared encodings for the RV32M issue controller: funct3 values, MCycleOp codes,
// controller states and the special operand constants.
package mach_v_mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] MC_MUL_S = 2'b00;
  localparam logic [1:0] MC_MUL_U = 2'b01;
  localparam logic [1:0] MC_DIV_S = 2'b10;
  localparam logic [1:0] MC_DIV_U = 2'b11;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_FAST  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  // MULHSU runs as an unsigned multiply and is corrected afterwards.
  function automatic logic [1:0] mc_op_of(input logic [2:0] funct3);
    logic [1:0] op;
    op = MC_MUL_S;
    case (funct3)
      F3_MUL, F3_MULH:     op = MC_MUL_S;
      F3_MULHSU, F3_MULHU: op = MC_MUL_U;
      F3_DIV, F3_REM:      op = MC_DIV_S;
      default:             op = MC_DIV_U;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mcycle_issue_ctrl_if.sv
// Pipeline request/writeback and MCycle Start/Busy signals of the issue controller.
// Handshake: a request is accepted on a rising CLK edge where ReqValid and ReqReady are both high; WbValid is a single-cycle strobe with no back-pressure.
interface mcycle_issue_ctrl_if #(
  parameter int width   = 32,
  parameter int rd_bits = 5
);
  logic               ReqValid;
  logic               ReqReady;
  logic [2:0]         ReqFunct3;
  logic [rd_bits-1:0] ReqRd;
  logic [width-1:0]   ReqOp1;
  logic [width-1:0]   ReqOp2;
  logic               Flush;
  logic               Stall;
  logic               MC_Reset;
  logic               MC_Start;
  logic [1:0]         MC_Op;
  logic [width-1:0]   MC_Operand1;
  logic [width-1:0]   MC_Operand2;
  logic [width-1:0]   MC_Result1;
  logic [width-1:0]   MC_Result2;
  logic               MC_Busy;
  logic               WbValid;
  logic [rd_bits-1:0] WbRd;
  logic [width-1:0]   WbData;

  modport master (
    input  ReqValid, ReqFunct3, ReqRd, ReqOp1, ReqOp2, Flush,
    input  MC_Result1, MC_Result2, MC_Busy,
    output ReqReady, Stall, MC_Reset, MC_Start, MC_Op, MC_Operand1, MC_Operand2,
    output WbValid, WbRd, WbData
  );

  modport slave (
    output ReqValid, ReqFunct3, ReqRd, ReqOp1, ReqOp2, Flush,
    output MC_Result1, MC_Result2, MC_Busy,
    input  ReqReady, Stall, MC_Reset, MC_Start, MC_Op, MC_Operand1, MC_Operand2,
    input  WbValid, WbRd, WbData
  );
endinterface

// File: rtl/mdu_fastpath.sv
// Detects RV32M divides whose result is fixed by the ISA (divide by zero,
// signed overflow) and produces that result without using MCycle.
module mdu_fastpath
  import mach_v_mdu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [2:0]       funct3,
  input  logic [width-1:0] op1,
  input  logic [width-1:0] op2,
  output logic             is_special,
  output logic [width-1:0] special_result
);
  localparam logic [width-1:0] MIN_NEG = {1'b1, {(width-1){1'b0}}};

  logic div_zero;
  logic overflow;

  always_comb begin
    is_special     = 1'b0;
    special_result = '0;
    div_zero       = funct3[2] && (op2 == '0);
    overflow       = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (op1 == MIN_NEG) && (op2 == '1);
    // funct3[1] separates the remainder ops from the quotient ops.
    if (div_zero) begin
      is_special     = 1'b1;
      special_result = funct3[1] ? op1 : '1;
    end else if (overflow) begin
      is_special     = 1'b1;
      special_result = funct3[1] ? '0 : MIN_NEG;
    end
  end
endmodule

// File: rtl/mcycle_issue_ctrl.sv
// Issues one RV32M op to the MCycle unit (or resolves it locally on the fast path),
// applies RISC-V result selection and returns a single writeback strobe.
module mcycle_issue_ctrl
  import mach_v_mdu_pkg::*;
#(
  parameter int width   = 32,
  parameter int rd_bits = 5
) (
  input  logic                CLK,
  input  logic                RESETn,
  mcycle_issue_ctrl_if.master bus,
  output state_t              dbg_state
);
  state_t             state, next_state;
  logic [2:0]         f3_r;
  logic [rd_bits-1:0] rd_r;
  logic [width-1:0]   op1_r, op2_r, special_r, sel_result;
  logic [width-1:0]   fp_result;
  logic [1:0]         mc_op_r;
  logic               mc_start_r, abort_r, fp_special, accept;
  logic               wb_valid_r;
  logic [rd_bits-1:0] wb_rd_r;
  logic [width-1:0]   wb_data_r;

  mdu_fastpath #(.width(width)) u_fastpath (
    .funct3         (bus.ReqFunct3),
    .op1            (bus.ReqOp1),
    .op2            (bus.ReqOp2),
    .is_special     (fp_special),
    .special_result (fp_result)
  );

  assign bus.ReqReady    = (state == ST_IDLE) && !bus.Flush;
  assign accept          = bus.ReqValid && bus.ReqReady;
  assign bus.Stall       = (state != ST_IDLE);
  assign bus.MC_Reset    = !RESETn || abort_r;
  assign bus.MC_Start    = mc_start_r;
  assign bus.MC_Op       = mc_op_r;
  assign bus.MC_Operand1 = op1_r;
  assign bus.MC_Operand2 = op2_r;
  assign bus.WbValid     = wb_valid_r;
  assign bus.WbRd        = wb_rd_r;
  assign bus.WbData      = wb_data_r;
  assign dbg_state       = state;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = fp_special ? ST_FAST : ST_ISSUE;
      ST_ISSUE: next_state = bus.Flush ? ST_ABORT : ST_WAIT;
      ST_FAST:  next_state = bus.Flush ? ST_ABORT : ST_DONE;
      ST_WAIT: begin
        if (bus.Flush)         next_state = ST_ABORT;
        else if (!bus.MC_Busy) next_state = ST_DONE;
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  // MULHSU: the unsigned high word over-counts by op2 when op1 is negative.
  always_comb begin
    sel_result = bus.MC_Result2;
    case (f3_r)
      F3_MUL, F3_DIV, F3_DIVU: sel_result = bus.MC_Result1;
      F3_MULHSU: sel_result = bus.MC_Result2 - (op1_r[width-1] ? op2_r : '0);
      default:   sel_result = bus.MC_Result2;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= ST_IDLE;
      f3_r       <= '0;
      rd_r       <= '0;
      op1_r      <= '0;
      op2_r      <= '0;
      special_r  <= '0;
      mc_op_r    <= '0;
      mc_start_r <= 1'b0;
      abort_r    <= 1'b0;
      wb_valid_r <= 1'b0;
      wb_rd_r    <= '0;
      wb_data_r  <= '0;
    end else begin
      state      <= next_state;
      mc_start_r <= (next_state == ST_ISSUE);
      abort_r    <= (next_state == ST_ABORT);
      wb_valid_r <= (next_state == ST_DONE);
      if (accept) begin
        f3_r      <= bus.ReqFunct3;
        rd_r      <= bus.ReqRd;
        op1_r     <= bus.ReqOp1;
        op2_r     <= bus.ReqOp2;
        special_r <= fp_result;
        mc_op_r   <= mc_op_of(bus.ReqFunct3);
      end
      if (next_state == ST_DONE) begin
        wb_rd_r   <= rd_r;
        wb_data_r <= (state == ST_FAST) ? special_r : sel_result;
      end
    end
  end
endmodule
